// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues req/ack fetches, absorbs
// hazard stalls in a one-entry hold buffer and squashes fetches on redirect.
//
// Handshake: a fetch is in flight on every cycle imem_req is high; imem_addr
// stays constant until the cycle imem_ack is seen with imem_req high, and
// that cycle's imem_rdata is the word for imem_addr. imem_req only drops in
// HOLD or under reset. The downstream side has no ready: valid marks a real
// instruction, and it is consumed at the clock edge when stall is low.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] npc,
  output logic [31:0] ir
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [31:0] fetch_pc, fetch_pc_next;
  logic [31:0] req_addr, req_addr_next;
  logic [31:0] hold_ir, hold_ir_next;
  logic [31:0] hold_pc, hold_pc_next;
  logic [31:0] target;

  // Redirect targets are word aligned regardless of the low bits from EX.
  assign target = redirect_pc & ~32'h3;
  assign npc    = pc + 32'd4;

  // State and data registers; all next values come from the block below.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      hold_ir  <= NOP;
      hold_pc  <= RESET_PC;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      req_addr <= req_addr_next;
      hold_ir  <= hold_ir_next;
      hold_pc  <= hold_pc_next;
    end
  end

  // Next-state and output decode; redirect takes priority in every state.
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    req_addr_next = req_addr;
    hold_ir_next  = hold_ir;
    hold_pc_next  = hold_pc;
    imem_req      = 1'b0;
    imem_addr     = fetch_pc;
    valid         = 1'b0;
    pc            = fetch_pc;
    ir            = NOP;

    case (state)
      FETCH: begin
        imem_req = 1'b1;
        if (redirect) begin
          fetch_pc_next = target;
          if (!imem_ack) begin
            // The fetch in flight must still complete; remember its address.
            req_addr_next = fetch_pc;
            state_next    = DISCARD;
          end
        end else if (imem_ack) begin
          valid = 1'b1;
          ir    = imem_rdata;
          if (stall) begin
            hold_ir_next = imem_rdata;
            hold_pc_next = fetch_pc;
            state_next   = HOLD;
          end else begin
            fetch_pc_next = fetch_pc + 32'd4;
          end
        end
      end

      HOLD: begin
        pc = hold_pc;
        if (redirect) begin
          fetch_pc_next = target;
          state_next    = FETCH;
        end else begin
          valid = 1'b1;
          ir    = hold_ir;
          if (!stall) begin
            fetch_pc_next = hold_pc + 32'd4;
            state_next    = FETCH;
          end
        end
      end

      DISCARD: begin
        imem_req  = 1'b1;
        imem_addr = req_addr;
        if (redirect) begin
          fetch_pc_next = target;
        end
        if (imem_ack) begin
          state_next = FETCH;
        end
      end

      default: begin
        state_next = FETCH;
      end
    endcase

    // While reset is held the stage presents its reset values and issues
    // no request, whatever the state register currently holds.
    if (rst) begin
      imem_req = 1'b0;
      valid    = 1'b0;
      pc       = RESET_PC;
      ir       = NOP;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a behavioural instruction memory with configurable
// wait states, a scoreboard of expected (pc, ir) pairs popped whenever IF/ID
// would load, and one task per scenario with inline checks.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        valid;
  logic [31:0] pc;
  logic [31:0] npc;
  logic [31:0] ir;

  int n_cmp = 0;
  int n_bad = 0;
  int waits = 0;
  int cnt = 0;

  logic [63:0] exp_q[$];
  logic [63:0] mon_e;

  if_stage #(.RESET_PC(32'h0), .NOP(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .valid(valid), .pc(pc),
    .npc(npc), .ir(ir)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  function automatic logic [63:0] exp_of(input logic [31:0] a);
    return {a, mem_word(a)};
  endfunction

  // Memory response: ack after `waits` wait cycles of a continuous request.
  always @(negedge clk) begin
    if (imem_req === 1'b1 && cnt >= waits) begin
      imem_ack   = 1'b1;
      imem_rdata = mem_word(imem_addr);
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
    end
  end

  always @(posedge clk) begin
    if (imem_req !== 1'b1 || imem_ack) cnt = 0;
    else cnt = cnt + 1;
  end

  // Scoreboard: an instruction is consumed when valid and not stalled.
  always @(negedge clk) begin
    #2;
    if (valid === 1'b1) begin
      if (!stall) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL sb_unexpected: got pc=%h ir=%h, queue empty", pc, ir);
        end else begin
          mon_e = exp_q.pop_front();
          if ({pc, ir} !== mon_e || npc !== mon_e[63:32] + 32'd4) begin
            n_bad++;
            $display("FAIL sb_instr: got pc=%h npc=%h ir=%h, want pc=%h npc=%h ir=%h",
                     pc, npc, ir, mon_e[63:32], mon_e[63:32] + 32'd4, mon_e[31:0]);
          end
        end
      end
    end else begin
      n_cmp++;
      if (ir !== NOP) begin
        n_bad++;
        $display("FAIL bubble_ir: got ir=%h, want %h", ir, NOP);
      end
    end
  end

  // driver tasks
  task automatic do_reset(input int w);
    waits    = w;
    stall    = 1'b0;
    redirect = 1'b0;
    rst      = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    exp_q.delete();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    waits = 0;
    rst   = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk); #2;
    n_cmp += 5;
    if (imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", imem_req); end
    if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid); end
    if (ir !== NOP) begin n_bad++; $display("FAIL reset_ir: got %h want %h", ir, NOP); end
    if (pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h want 0", pc); end
    if (npc !== 32'h4) begin n_bad++; $display("FAIL reset_npc: got %h want 4", npc); end
  endtask

  task automatic test_zero_wait;
    do_reset(0);
    for (int k = 0; k < 4; k++) exp_q.push_back(exp_of(32'(4 * k)));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #2;
      n_cmp += 2;
      if (valid !== 1'b1) begin n_bad++; $display("FAIL zw_valid c%0d: got %b want 1", i, valid); end
      if (imem_addr !== 32'(4 * i)) begin n_bad++; $display("FAIL zw_addr c%0d: got %h want %h", i, imem_addr, 32'(4 * i)); end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL zw_drain: %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_wait2;
    do_reset(2);
    for (int k = 0; k < 3; k++) exp_q.push_back(exp_of(32'(4 * k)));
    for (int i = 0; i < 9; i++) begin
      @(negedge clk); #2;
      n_cmp += 3;
      if (valid !== (i % 3 == 2)) begin n_bad++; $display("FAIL w2_valid c%0d: got %b want %b", i, valid, (i % 3 == 2)); end
      if (imem_addr !== 32'(4 * (i / 3))) begin n_bad++; $display("FAIL w2_addr c%0d: got %h want %h", i, imem_addr, 32'(4 * (i / 3))); end
      if (imem_req !== 1'b1) begin n_bad++; $display("FAIL w2_req c%0d: got %b want 1", i, imem_req); end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL w2_drain: %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_stall;
    do_reset(0);
    for (int k = 0; k < 5; k++) exp_q.push_back(exp_of(32'(4 * k)));
    for (int i = 0; i < 8; i++) begin
      stall = (i >= 2 && i <= 4);
      @(negedge clk); #2;
      if (i == 3 || i == 4) begin
        n_cmp += 3;
        if (imem_req !== 1'b0) begin n_bad++; $display("FAIL st_req c%0d: got %b want 0", i, imem_req); end
        if (pc !== 32'h8) begin n_bad++; $display("FAIL st_pc c%0d: got %h want 8", i, pc); end
        if (valid !== 1'b1) begin n_bad++; $display("FAIL st_valid c%0d: got %b want 1", i, valid); end
      end
      if (i == 6) begin
        n_cmp++;
        if (imem_addr !== 32'hC) begin n_bad++; $display("FAIL st_next: got %h want c", imem_addr); end
      end
      @(posedge clk); #1;
    end
    stall = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL st_drain: %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_redirect;
    do_reset(2);
    for (int k = 0; k < 4; k++) exp_q.push_back(exp_of(32'(4 * k)));
    exp_q.push_back(exp_of(32'h100));
    redirect_pc = 32'h103;
    for (int i = 0; i < 18; i++) begin
      redirect = (i == 12);
      @(negedge clk); #2;
      if (i == 13) begin
        n_cmp += 2;
        if (imem_addr !== 32'h10) begin n_bad++; $display("FAIL rd_addr: got %h want 10", imem_addr); end
        if (imem_req !== 1'b1) begin n_bad++; $display("FAIL rd_req: got %b want 1", imem_req); end
      end
      if (i >= 12 && i <= 16) begin
        n_cmp++;
        if (valid !== 1'b0) begin n_bad++; $display("FAIL rd_dead c%0d: got %b want 0", i, valid); end
      end
      if (i == 15) begin
        n_cmp++;
        if (imem_addr !== 32'h100) begin n_bad++; $display("FAIL rd_target: got %h want 100", imem_addr); end
      end
      if (i == 17) begin
        n_cmp++;
        if (valid !== 1'b1 || pc !== 32'h100) begin n_bad++; $display("FAIL rd_present: got v=%b pc=%h want v=1 pc=100", valid, pc); end
      end
      @(posedge clk); #1;
    end
    redirect = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL rd_drain: %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_redirect_stall_ack;
    do_reset(0);
    exp_q.push_back(exp_of(32'h0));
    exp_q.push_back(exp_of(32'h40));
    exp_q.push_back(exp_of(32'h44));
    redirect_pc = 32'h40;
    for (int i = 0; i < 4; i++) begin
      redirect = (i == 1);
      stall    = (i == 1);
      @(negedge clk); #2;
      if (i == 1) begin
        n_cmp += 2;
        if (valid !== 1'b0) begin n_bad++; $display("FAIL rs_valid: got %b want 0", valid); end
        if (imem_ack !== 1'b1) begin n_bad++; $display("FAIL rs_ack_cycle: got ack %b want 1", imem_ack); end
      end
      if (i == 2) begin
        n_cmp++;
        if (valid !== 1'b1 || pc !== 32'h40) begin n_bad++; $display("FAIL rs_target: got v=%b pc=%h want v=1 pc=40", valid, pc); end
      end
      @(posedge clk); #1;
    end
    redirect = 1'b0;
    stall    = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL rs_drain: %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_wrap;
    do_reset(0);
    exp_q.push_back(exp_of(32'hFFFF_FFFC));
    exp_q.push_back(exp_of(32'h0));
    exp_q.push_back(exp_of(32'h4));
    redirect_pc = 32'hFFFF_FFFC;
    for (int i = 0; i < 4; i++) begin
      redirect = (i == 0);
      @(negedge clk); #2;
      if (i == 1) begin
        n_cmp += 2;
        if (pc !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wr_pc: got %h want fffffffc", pc); end
        if (npc !== 32'h0) begin n_bad++; $display("FAIL wr_npc: got %h want 0", npc); end
      end
      if (i == 2) begin
        n_cmp++;
        if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL wr_addr: got %h want 0", imem_addr); end
      end
      @(posedge clk); #1;
    end
    redirect = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL wr_drain: %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_reset_discard;
    do_reset(2);
    exp_q.push_back(exp_of(32'h0));
    redirect_pc = 32'h200;
    for (int i = 0; i < 5; i++) begin
      redirect = (i == 0);
      rst      = (i == 1);
      @(negedge clk); #2;
      if (i == 1) begin
        n_cmp += 3;
        if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rdc_req: got %b want 0", imem_req); end
        if (pc !== 32'h0) begin n_bad++; $display("FAIL rdc_pc: got %h want 0", pc); end
        if (valid !== 1'b0) begin n_bad++; $display("FAIL rdc_valid: got %b want 0", valid); end
      end
      if (i == 2) begin
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_bad++; $display("FAIL rdc_restart: got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr); end
      end
      if (i == 4) begin
        n_cmp++;
        if (valid !== 1'b1 || pc !== 32'h0) begin n_bad++; $display("FAIL rdc_present: got v=%b pc=%h want v=1 pc=0", valid, pc); end
      end
      @(posedge clk); #1;
    end
    redirect = 1'b0;
    rst      = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL rdc_drain: %0d left want 0", exp_q.size()); end
  endtask

  // sequence and final report
  initial begin
    test_reset();
    test_zero_wait();
    test_wait2();
    test_stall();
    test_redirect();
    test_redirect_stall_ack();
    test_wrap();
    test_reset_discard();
    rst = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
